// File: rtl/axis_packet_monitor.sv
// AXI-Stream sink checker: measures packet byte length, validates length window,
// tkeep shape and tid stability, and publishes one report per packet plus statistics.
module axis_packet_monitor #(
  parameter int ID_WIDTH    = 10,
  parameter int DATA_WIDTH  = 32,
  parameter int TKEEP_WIDTH = DATA_WIDTH / 8,
  parameter int LEN_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [ID_WIDTH-1:0]    s_axis_tid_i,
  input  logic [DATA_WIDTH-1:0]  s_axis_tdata_i,
  input  logic                   s_axis_tvalid_i,
  input  logic                   s_axis_tlast_i,
  input  logic [TKEEP_WIDTH-1:0] s_axis_tkeep_i,
  output logic                   s_axis_tready_o,
  input  logic                   ready_mask_i,
  input  logic                   clear_i,
  input  logic [LEN_WIDTH-1:0]   min_len_i,
  input  logic [LEN_WIDTH-1:0]   max_len_i,
  output logic                   rpt_valid_o,
  input  logic                   rpt_ready_i,
  output logic [ID_WIDTH-1:0]    rpt_tid_o,
  output logic [LEN_WIDTH-1:0]   rpt_len_o,
  output logic [3:0]             rpt_err_o,
  output logic [31:0]            stat_pkt_cnt_o,
  output logic [31:0]            stat_byte_cnt_o,
  output logic [31:0]            stat_err_cnt_o,
  output logic [31:0]            stat_drop_cnt_o,
  output logic [LEN_WIDTH-1:0]   stat_min_len_o,
  output logic [LEN_WIDTH-1:0]   stat_max_len_o
);

  typedef enum logic {IDLE, IN_PKT} state_t;

  state_t                 r_state, w_state_nxt;
  logic [ID_WIDTH-1:0]    r_tid;
  logic [LEN_WIDTH-1:0]   r_len;
  logic                   r_sat, r_keep_err, r_tid_err;

  logic                   r_rpt_valid;
  logic [ID_WIDTH-1:0]    r_rpt_tid;
  logic [LEN_WIDTH-1:0]   r_rpt_len;
  logic [3:0]             r_rpt_err;

  logic [31:0]            r_pkt_cnt, r_byte_cnt, r_err_cnt, r_drop_cnt;
  logic [LEN_WIDTH-1:0]   r_min_len, r_max_len;

  logic                   w_beat, w_done, w_in_pkt, w_rpt_take, w_drop, w_load;
  logic [LEN_WIDTH-1:0]   w_pc, w_base, w_len_nxt;
  logic [LEN_WIDTH:0]     w_sum;
  logic                   w_sat_nxt, w_keep_bad, w_keep_err_nxt, w_tid_err_nxt;
  logic [TKEEP_WIDTH-1:0] w_keep_p1;
  logic [ID_WIDTH-1:0]    w_tid_cap;
  logic [3:0]             w_err;
  logic                   w_unused_tdata;

  assign w_unused_tdata = ^s_axis_tdata_i;

  function automatic logic [LEN_WIDTH-1:0] popcnt(input logic [TKEEP_WIDTH-1:0] k);
    popcnt = '0;
    for (int i = 0; i < TKEEP_WIDTH; i++) popcnt = popcnt + LEN_WIDTH'(k[i]);
  endfunction

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    sat_add = s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  assign s_axis_tready_o = ready_mask_i && !reset;

  always_comb begin
    w_beat         = s_axis_tvalid_i && s_axis_tready_o;
    w_done         = w_beat && s_axis_tlast_i;
    w_in_pkt       = (r_state == IN_PKT);
    w_pc           = popcnt(s_axis_tkeep_i);
    w_base         = w_in_pkt ? r_len : '0;
    w_sum          = {1'b0, w_base} + {1'b0, w_pc};
    w_len_nxt      = w_sum[LEN_WIDTH] ? '1 : w_sum[LEN_WIDTH-1:0];
    w_sat_nxt      = (w_in_pkt && r_sat) || w_sum[LEN_WIDTH];
    // A last beat must be a contiguous low-aligned run of at least one byte.
    w_keep_p1      = s_axis_tkeep_i + TKEEP_WIDTH'(1);
    w_keep_bad     = s_axis_tlast_i ?
                     ((s_axis_tkeep_i == '0) || ((s_axis_tkeep_i & w_keep_p1) != '0)) :
                     (s_axis_tkeep_i != '1);
    w_keep_err_nxt = (w_in_pkt && r_keep_err) || w_keep_bad;
    w_tid_err_nxt  = w_in_pkt && (r_tid_err || (s_axis_tid_i != r_tid));
    w_tid_cap      = w_in_pkt ? r_tid : s_axis_tid_i;
    w_err          = {w_tid_err_nxt, w_keep_err_nxt,
                      (w_len_nxt > max_len_i) || w_sat_nxt, w_len_nxt < min_len_i};
    w_rpt_take     = r_rpt_valid && rpt_ready_i;
    w_load         = w_done && (!r_rpt_valid || w_rpt_take);
    w_drop         = w_done && r_rpt_valid && !rpt_ready_i;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_beat) w_state_nxt = s_axis_tlast_i ? IDLE : IN_PKT;
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tid      <= '0;
      r_len      <= '0;
      r_sat      <= 1'b0;
      r_keep_err <= 1'b0;
      r_tid_err  <= 1'b0;
    end else if (w_beat) begin
      r_tid      <= w_tid_cap;
      r_len      <= w_len_nxt;
      r_sat      <= w_sat_nxt;
      r_keep_err <= w_keep_err_nxt;
      r_tid_err  <= w_tid_err_nxt;
    end
  end

  // Single-entry report slot; a completion can refill it in the cycle it drains.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rpt_valid <= 1'b0;
      r_rpt_tid   <= '0;
      r_rpt_len   <= '0;
      r_rpt_err   <= '0;
    end else if (w_load) begin
      r_rpt_valid <= 1'b1;
      r_rpt_tid   <= w_tid_cap;
      r_rpt_len   <= w_len_nxt;
      r_rpt_err   <= w_err;
    end else if (w_rpt_take) begin
      r_rpt_valid <= 1'b0;
    end
  end

  // Clear overrides a coinciding completion, so that packet goes uncounted.
  always_ff @(posedge clk) begin
    if (reset || clear_i) begin
      r_pkt_cnt  <= '0;
      r_byte_cnt <= '0;
      r_err_cnt  <= '0;
      r_drop_cnt <= '0;
      r_min_len  <= '1;
      r_max_len  <= '0;
    end else if (w_done) begin
      r_pkt_cnt  <= sat_add(r_pkt_cnt, 32'd1);
      r_byte_cnt <= sat_add(r_byte_cnt, 32'(w_len_nxt));
      if (w_err != '0)            r_err_cnt  <= sat_add(r_err_cnt, 32'd1);
      if (w_drop)                 r_drop_cnt <= sat_add(r_drop_cnt, 32'd1);
      if (w_len_nxt < r_min_len)  r_min_len  <= w_len_nxt;
      if (w_len_nxt > r_max_len)  r_max_len  <= w_len_nxt;
    end
  end

  assign rpt_valid_o     = r_rpt_valid;
  assign rpt_tid_o       = r_rpt_tid;
  assign rpt_len_o       = r_rpt_len;
  assign rpt_err_o       = r_rpt_err;
  assign stat_pkt_cnt_o  = r_pkt_cnt;
  assign stat_byte_cnt_o = r_byte_cnt;
  assign stat_err_cnt_o  = r_err_cnt;
  assign stat_drop_cnt_o = r_drop_cnt;
  assign stat_min_len_o  = r_min_len;
  assign stat_max_len_o  = r_max_len;

endmodule

// File: tb/tb_axis_packet_monitor.sv
// Directed bench for axis_packet_monitor: hand-computed lengths, error flags and statistics.
module tb_axis_packet_monitor;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  tid;
  logic [31:0] tdata;
  logic        tvalid, tlast;
  logic [3:0]  tkeep;
  logic        tready;
  logic        ready_mask, clear, rpt_ready;
  logic [15:0] min_len, max_len;
  logic        rpt_valid;
  logic [9:0]  rpt_tid;
  logic [15:0] rpt_len;
  logic [3:0]  rpt_err;
  logic [31:0] pkt_cnt, byte_cnt, err_cnt, drop_cnt;
  logic [15:0] smin, smax;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  axis_packet_monitor dut (
    .clk(clk), .reset(reset),
    .s_axis_tid_i(tid), .s_axis_tdata_i(tdata), .s_axis_tvalid_i(tvalid),
    .s_axis_tlast_i(tlast), .s_axis_tkeep_i(tkeep), .s_axis_tready_o(tready),
    .ready_mask_i(ready_mask), .clear_i(clear),
    .min_len_i(min_len), .max_len_i(max_len),
    .rpt_valid_o(rpt_valid), .rpt_ready_i(rpt_ready),
    .rpt_tid_o(rpt_tid), .rpt_len_o(rpt_len), .rpt_err_o(rpt_err),
    .stat_pkt_cnt_o(pkt_cnt), .stat_byte_cnt_o(byte_cnt),
    .stat_err_cnt_o(err_cnt), .stat_drop_cnt_o(drop_cnt),
    .stat_min_len_o(smin), .stat_max_len_o(smax)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [9:0] t, input logic [3:0] k, input logic l);
    tvalid = 1'b1; tid = t; tkeep = k; tlast = l; tdata = $urandom;
    tick();
    tvalid = 1'b0; tlast = 1'b0;
  endtask

  task automatic send_len(input logic [9:0] t, input int len);
    int nfull, rem;
    logic [3:0] k;
    nfull = (len - 1) / 4;
    rem   = len - 4 * nfull;
    k     = 4'((1 << rem) - 1);
    for (int i = 0; i < nfull; i++) beat(t, 4'hF, 1'b0);
    beat(t, k, 1'b1);
  endtask

  task automatic pulse_clear();
    clear = 1'b1; tick(); clear = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; ready_mask = 1'b1;
    tick(); tick();
    total++; if (tready !== 1'b0) begin bad++; $display("FAIL reset_tready got=%0b exp=0", tready); end
    reset = 1'b0;
    tick();
    total++; if (rpt_valid !== 1'b0) begin bad++; $display("FAIL reset_rpt_valid got=%0b exp=0", rpt_valid); end
    total++; if ({pkt_cnt, byte_cnt, err_cnt, drop_cnt} !== 128'd0) begin bad++; $display("FAIL reset_counters got=%0h/%0h/%0h/%0h exp=0", pkt_cnt, byte_cnt, err_cnt, drop_cnt); end
    total++; if (smin !== 16'hFFFF || smax !== 16'h0) begin bad++; $display("FAIL reset_minmax got=%0h/%0h exp=ffff/0", smin, smax); end
    total++; if (tready !== 1'b1) begin bad++; $display("FAIL tready_after_reset got=%0b exp=1", tready); end
  endtask

  task automatic test_single();
    min_len = 16'd1; max_len = 16'd16;
    beat(10'd3, 4'b0111, 1'b1);
    total++; if (rpt_valid !== 1'b1 || rpt_tid !== 10'd3 || rpt_len !== 16'd3 || rpt_err !== 4'd0) begin bad++; $display("FAIL single_rpt got=%0b/%0d/%0d/%0b exp=1/3/3/0000", rpt_valid, rpt_tid, rpt_len, rpt_err); end
    total++; if (pkt_cnt !== 32'd1 || byte_cnt !== 32'd3) begin bad++; $display("FAIL single_stats got=%0d/%0d exp=1/3", pkt_cnt, byte_cnt); end
    tick();
    total++; if (rpt_valid !== 1'b0) begin bad++; $display("FAIL single_consumed got=%0b exp=0", rpt_valid); end
  endtask

  task automatic test_multi();
    beat(10'd5, 4'hF, 1'b0); beat(10'd5, 4'hF, 1'b0); beat(10'd5, 4'hF, 1'b0);
    total++; if (rpt_valid !== 1'b0) begin bad++; $display("FAIL multi_early_valid got=%0b exp=0", rpt_valid); end
    beat(10'd5, 4'b0011, 1'b1);
    total++; if (rpt_valid !== 1'b1 || rpt_len !== 16'd14 || rpt_tid !== 10'd5 || rpt_err !== 4'd0) begin bad++; $display("FAIL multi_rpt got=%0b/%0d/%0d/%0b exp=1/14/5/0000", rpt_valid, rpt_len, rpt_tid, rpt_err); end
    tick();
  endtask

  task automatic test_errors();
    pulse_clear();
    beat(10'd5, 4'hF, 1'b0); beat(10'd5, 4'b0111, 1'b0); beat(10'd5, 4'hF, 1'b1);
    total++; if (rpt_err !== 4'b0100 || rpt_len !== 16'd11) begin bad++; $display("FAIL keep_err got=%0b/%0d exp=0100/11", rpt_err, rpt_len); end
    beat(10'd5, 4'hF, 1'b0); beat(10'd6, 4'hF, 1'b0); beat(10'd6, 4'hF, 1'b1);
    total++; if (rpt_err !== 4'b1000 || rpt_tid !== 10'd5) begin bad++; $display("FAIL tid_err got=%0b/%0d exp=1000/5", rpt_err, rpt_tid); end
    total++; if (err_cnt !== 32'd2) begin bad++; $display("FAIL err_cnt got=%0d exp=2", err_cnt); end
    tick();
  endtask

  task automatic test_window();
    int lens [4] = '{63, 64, 1600, 1601};
    logic [3:0] errs [4] = '{4'b0001, 4'b0000, 4'b0000, 4'b0010};
    pulse_clear();
    min_len = 16'd64; max_len = 16'd1600;
    for (int i = 0; i < 4; i++) begin
      send_len(10'(20 + i), lens[i]);
      total++; if (rpt_err !== errs[i] || rpt_len !== 16'(lens[i])) begin bad++; $display("FAIL window_%0d got=%0b/%0d exp=%0b/%0d", i, rpt_err, rpt_len, errs[i], lens[i]); end
    end
    total++; if (smin !== 16'd63 || smax !== 16'd1601) begin bad++; $display("FAIL window_minmax got=%0d/%0d exp=63/1601", smin, smax); end
    total++; if (byte_cnt !== 32'd3328 || pkt_cnt !== 32'd4) begin bad++; $display("FAIL window_bytes got=%0d/%0d exp=3328/4", byte_cnt, pkt_cnt); end
    tick();
  endtask

  task automatic test_min_gt_max();
    min_len = 16'd20; max_len = 16'd10;
    send_len(10'd9, 15);
    total++; if (rpt_err !== 4'b0011) begin bad++; $display("FAIL min_gt_max got=%0b exp=0011", rpt_err); end
    tick();
    min_len = 16'd1; max_len = 16'd16;
  endtask

  task automatic test_back_to_back();
    pulse_clear();
    rpt_ready = 1'b0;
    send_len(10'd1, 4); send_len(10'd2, 4); send_len(10'd3, 4);
    total++; if (rpt_valid !== 1'b1 || rpt_tid !== 10'd1 || rpt_len !== 16'd4) begin bad++; $display("FAIL held_rpt got=%0b/%0d/%0d exp=1/1/4", rpt_valid, rpt_tid, rpt_len); end
    total++; if (drop_cnt !== 32'd2 || pkt_cnt !== 32'd3) begin bad++; $display("FAIL drop_cnt got=%0d/%0d exp=2/3", drop_cnt, pkt_cnt); end
    rpt_ready = 1'b1;
    send_len(10'd4, 2);
    total++; if (rpt_valid !== 1'b1 || rpt_tid !== 10'd4 || rpt_len !== 16'd2) begin bad++; $display("FAIL swap_rpt got=%0b/%0d/%0d exp=1/4/2", rpt_valid, rpt_tid, rpt_len); end
    total++; if (drop_cnt !== 32'd2) begin bad++; $display("FAIL swap_drop got=%0d exp=2", drop_cnt); end
    tick();
  endtask

  task automatic test_clear_coincide();
    clear = 1'b1;
    send_len(10'd10, 4);
    clear = 1'b0;
    total++; if (rpt_valid !== 1'b1 || rpt_tid !== 10'd10) begin bad++; $display("FAIL clear_rpt got=%0b/%0d exp=1/10", rpt_valid, rpt_tid); end
    total++; if (pkt_cnt !== 32'd0 || byte_cnt !== 32'd0 || smin !== 16'hFFFF) begin bad++; $display("FAIL clear_stats got=%0d/%0d/%0h exp=0/0/ffff", pkt_cnt, byte_cnt, smin); end
    tick();
  endtask

  task automatic test_reset_mid();
    beat(10'd7, 4'hF, 1'b0); beat(10'd7, 4'hF, 1'b0);
    reset = 1'b1; tick(); reset = 1'b0;
    send_len(10'd8, 4);
    total++; if (rpt_len !== 16'd4 || rpt_tid !== 10'd8 || rpt_err !== 4'd0 || pkt_cnt !== 32'd1) begin bad++; $display("FAIL reset_mid got=%0d/%0d/%0b/%0d exp=4/8/0000/1", rpt_len, rpt_tid, rpt_err, pkt_cnt); end
    ready_mask = 1'b0;
    tvalid = 1'b1; tlast = 1'b1; tkeep = 4'hF; tid = 10'd9;
    #1;
    total++; if (tready !== 1'b0) begin bad++; $display("FAIL mask_tready got=%0b exp=0", tready); end
    tick(); tick(); tick();
    tvalid = 1'b0; tlast = 1'b0;
    total++; if (pkt_cnt !== 32'd1 || rpt_valid !== 1'b0) begin bad++; $display("FAIL mask_noaccept got=%0d/%0b exp=1/0", pkt_cnt, rpt_valid); end
    ready_mask = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    tid = '0; tdata = '0; tvalid = 1'b0; tlast = 1'b0; tkeep = '0;
    ready_mask = 1'b1; clear = 1'b0; rpt_ready = 1'b1;
    min_len = 16'd1; max_len = 16'd16; reset = 1'b1;
    test_reset();
    test_single();
    test_multi();
    test_errors();
    test_window();
    test_min_gt_max();
    test_back_to_back();
    test_clear_coincide();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
